// File: rtl/rosc_pkg.sv
// Shared types for the ROSC reader: mode encodings, reader FSM states and
// the sample record carried through the sample FIFO.
package rosc_pkg;

  localparam logic [1:0] MODE_STOP = 2'b00;
  localparam logic [1:0] MODE_FAST = 2'b01;
  localparam logic [1:0] MODE_SLOW = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_READY,
    ACK,
    WAIT_CLEAR,
    DONE
  } rosc_rd_state_t;

  typedef struct packed {
    logic [2:0]  err;
    logic [15:0] reading;
  } rosc_sample_t;

endpackage

// File: rtl/rosc_sample_fifo.sv
// First-word-fall-through sample FIFO. The head entry is visible whenever
// notEmpty is high; an extra pointer bit separates full from empty, so a
// push and a pop in the same cycle are both honoured even when full.
module rosc_sample_fifo
  import rosc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         flush,
  input  logic         push,
  input  rosc_sample_t pushData,
  input  logic         pop,
  output rosc_sample_t headData,
  output logic         notEmpty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wrPtr;
  logic [AW:0]  rdPtr;
  rosc_sample_t mem [DEPTH];
  logic         doPush;
  logic         doPop;

  assign notEmpty = (wrPtr != rdPtr);
  assign full     = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign doPop    = pop && notEmpty;
  assign doPush   = push && (!full || doPop);
  assign headData = mem[rdPtr[AW-1:0]];

  // Storage and pointers; flush empties the FIFO without touching storage.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr[AW-1:0]] <= pushData;
        wrPtr              <= wrPtr + 1'b1;
      end
      if (doPop) rdPtr <= rdPtr + 1'b1;
    end
  end

endmodule

// File: rtl/rosc_reader.sv
// CPU-side reader for the ROSC sensor counter. Arms the ROSC, collects a
// programmed number of readings into the sample FIFO, keeps a running sum,
// and aborts any wait that outlasts the timeout.
//
// state      | meaning
// IDLE       | no run; waiting for Start
// ARM        | drive Mode/NumClkCycles, raise Enable
// WAIT_READY | wait for ROSCValReady; capture when FIFO has room
// ACK        | one-cycle CPUReadComplete pulse
// WAIT_CLEAR | wait for ROSCValReady to drop before the next capture
// DONE       | one-cycle Done pulse; ROSC stopped
module rosc_reader
  import rosc_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  Abort,
  input  logic [1:0]            CfgMode,
  input  logic [3:0]            CfgNumClkCycles,
  input  logic [CNT_W-1:0]      NumSamples,
  output logic [1:0]            Mode,
  output logic                  Enable,
  output logic [3:0]            NumClkCycles,
  output logic                  CPUReadComplete,
  input  logic [15:0]           ROSCReading,
  input  logic [2:0]            ErrorCode,
  input  logic                  ROSCValReady,
  output logic [15:0]           SampleData,
  output logic [2:0]            SampleErr,
  output logic                  SampleValid,
  input  logic                  SampleReady,
  output logic [16+CNT_W-1:0]   Sum,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Timeout,
  output logic                  SampleErrSeen
);

  localparam int              TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

  rosc_rd_state_t   state;
  rosc_rd_state_t   nextState;
  logic [CNT_W-1:0] numLat;
  logic [CNT_W-1:0] sampleCnt;
  logic [TMR_W-1:0] tmr;
  logic             startAccepted;
  logic             fifoFlush;
  logic             fifoPush;
  logic             fifoFull;
  logic             waiting;
  logic             stall;
  logic             tmrExpired;
  logic             timeoutHit;
  rosc_sample_t     pushData;
  rosc_sample_t     headData;

  assign startAccepted = (state == IDLE) && Start;
  assign fifoFlush     = startAccepted && (NumSamples != '0);
  assign waiting       = (state == WAIT_READY) || (state == WAIT_CLEAR);
  // A full FIFO holds the ROSC off; that wait is not the ROSC's fault, so the
  // timer is frozen rather than allowed to expire.
  assign stall         = (state == WAIT_READY) && fifoFull;
  assign tmrExpired    = waiting && !stall && (tmr == '0);
  assign pushData      = '{err: ErrorCode, reading: ROSCReading};

  assign SampleData  = headData.reading;
  assign SampleErr   = headData.err;

  rosc_sample_fifo #(.DEPTH(FIFO_DEPTH)) uFifo (
    .Clk      (Clk),
    .Reset    (Reset),
    .flush    (fifoFlush),
    .push     (fifoPush),
    .pushData (pushData),
    .pop      (SampleReady),
    .headData (headData),
    .notEmpty (SampleValid),
    .full     (fifoFull)
  );

  // Next-state decode; Abort overrides any capture or timeout in the same cycle.
  always_comb begin
    nextState  = state;
    fifoPush   = 1'b0;
    timeoutHit = 1'b0;
    case (state)
      IDLE:       if (Start) nextState = (NumSamples == '0) ? DONE : ARM;
      ARM:        nextState = WAIT_READY;
      WAIT_READY: begin
        if (ROSCValReady && !fifoFull) begin
          fifoPush  = 1'b1;
          nextState = ACK;
        end else if (tmrExpired) begin
          timeoutHit = 1'b1;
          nextState  = DONE;
        end
      end
      ACK:        nextState = WAIT_CLEAR;
      WAIT_CLEAR: begin
        if (!ROSCValReady) begin
          nextState = (sampleCnt == numLat) ? DONE : WAIT_READY;
        end else if (tmrExpired) begin
          timeoutHit = 1'b1;
          nextState  = DONE;
        end
      end
      DONE:       nextState = IDLE;
      default:    nextState = IDLE;
    endcase
    if (Abort && (state != IDLE) && (state != DONE)) begin
      nextState  = DONE;
      fifoPush   = 1'b0;
      timeoutHit = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= nextState;
  end

  // Sample count target for the run.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)          numLat <= '0;
    else if (fifoFlush) numLat <= NumSamples;
  end

  // Run accumulators and sticky status, cleared by an accepted Start.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Sum           <= '0;
      sampleCnt     <= '0;
      Timeout       <= 1'b0;
      SampleErrSeen <= 1'b0;
    end else if (startAccepted) begin
      Sum           <= '0;
      sampleCnt     <= '0;
      Timeout       <= 1'b0;
      SampleErrSeen <= 1'b0;
    end else begin
      if (fifoPush) begin
        Sum       <= Sum + (16+CNT_W)'(ROSCReading);
        sampleCnt <= sampleCnt + 1'b1;
        if (ErrorCode != 3'd0) SampleErrSeen <= 1'b1;
      end
      if (timeoutHit) Timeout <= 1'b1;
    end
  end

  // Wait-state down-counter: reloaded on entry to either wait state,
  // terminal count at zero.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      tmr <= '0;
    end else if ((nextState != state) &&
                 ((nextState == WAIT_READY) || (nextState == WAIT_CLEAR))) begin
      tmr <= TMR_LOAD;
    end else if (waiting && !stall && (tmr != '0)) begin
      tmr <= tmr - 1'b1;
    end
  end

  // Registered ROSC-facing and status outputs, decoded from the next state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Mode            <= MODE_STOP;
      NumClkCycles    <= '0;
      Enable          <= 1'b0;
      CPUReadComplete <= 1'b0;
      Busy            <= 1'b0;
      Done            <= 1'b0;
    end else begin
      if (fifoFlush) begin
        Mode         <= CfgMode;
        NumClkCycles <= CfgNumClkCycles;
      end else if (nextState == DONE) begin
        Mode <= MODE_STOP;
      end
      Enable          <= (nextState == ARM) || (nextState == WAIT_READY) ||
                         (nextState == ACK) || (nextState == WAIT_CLEAR);
      CPUReadComplete <= (nextState == ACK);
      Busy            <= (nextState != IDLE);
      Done            <= (nextState == DONE);
    end
  end

endmodule

// File: doc/rosc_reader.md
Name: rosc_reader

Overview:
- CPU-side controller for the ROSC sensor counter. It is the reader end of the ROSC handshake.
- It drives the ROSC inputs Mode, Enable, NumClkCycles and CPUReadComplete, and consumes ROSCReading, ErrorCode and ROSCValReady.
- It collects a programmed number of samples into a small FIFO, which the bus interface drains with a valid/ready handshake.
- It keeps a running sum of the collected readings for averaging.

Parameters:
- FIFO_DEPTH, 4, sample FIFO entries; power of 2, minimum 2.
- TIMEOUT_CYCLES, 256, Clk cycles allowed in any wait state before the run aborts.
- CNT_W, 8, width of NumSamples and the sample counter.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  one-cycle pulse that begins a run; ignored unless Busy=0.
- Abort  in  1  one-cycle pulse that terminates a run.
- CfgMode  in  2  ROSC mode for the run; latched on Start.
- CfgNumClkCycles  in  4  measurement window; latched on Start.
- NumSamples  in  CNT_W  samples to collect; latched on Start.
- Mode  out  2  ROSC mode.
- Enable  out  1  ROSC enable.
- NumClkCycles  out  4  ROSC window.
- CPUReadComplete  out  1  acknowledge to ROSC.
- ROSCReading  in  16  ROSC counter value.
- ErrorCode  in  3  ROSC error code.
- ROSCValReady  in  1  ROSC value-ready flag.
- SampleData  out  16  FIFO head reading.
- SampleErr  out  3  FIFO head error code.
- SampleValid  out  1  FIFO non-empty.
- SampleReady  in  1  consumer pop; a pop occurs when SampleValid=1 and SampleReady=1.
- Sum  out  16+CNT_W  sum of readings captured this run.
- Busy  out  1  run in progress.
- Done  out  1  one-cycle pulse at the end of a run.
- Timeout  out  1  sticky; cleared on Start.
- SampleErrSeen  out  1  sticky OR of nonzero ErrorCode at capture; cleared on Start.

Behaviour:
- Reset values: Mode=STOP, Enable=0, NumClkCycles=0, CPUReadComplete=0, FIFO empty, SampleValid=0, Sum=0, Busy=0, Done=0, Timeout=0, SampleErrSeen=0, state IDLE. All outputs are registered.
- IDLE:
  - On Start with NumSamples=0: go to DONE.
  - On Start otherwise: latch the configuration, flush the FIFO, clear Sum, Timeout, SampleErrSeen and the sample counter, then go to ARM.
- ARM (1 cycle): Mode=latched CfgMode, NumClkCycles=latched value, Enable=1. Go to WAIT_READY.
- WAIT_READY:
  - When ROSCValReady=1 and the FIFO is not full: push {ErrorCode, ROSCReading}, add the reading to Sum, increment the counter, set SampleErrSeen if ErrorCode!=0, then go to ACK.
  - When the FIFO is full: stall. Do not acknowledge. The ROSC holds its value, and the timeout counter is frozen while stalled.
- ACK (exactly 1 cycle): CPUReadComplete=1. Go to WAIT_CLEAR.
- WAIT_CLEAR:
  - Wait for ROSCValReady=0, so a single value is never captured twice.
  - Then, if counter==NumSamples, go to DONE; otherwise go to WAIT_READY.
- DONE (1 cycle): Enable=0, Mode=STOP, Done=1, Busy=0 from the next cycle. Go to IDLE. The FIFO contents are retained for draining.
- Busy=1 in every state except IDLE.
- Timeout:
  - A counter restarts on entry to WAIT_READY and WAIT_CLEAR.
  - When it reaches TIMEOUT_CYCLES: set Timeout and go to DONE.
- Abort in any non-IDLE state: go to DONE next cycle. Captured samples are kept. Abort has priority over a simultaneous capture; that sample is not pushed.
- Start while Busy=1 is ignored.
- FIFO:
  - Push and pop in the same cycle are both honoured, including when the FIFO is full.
  - Pointers wrap modulo FIFO_DEPTH. The full/empty distinction comes from an extra pointer bit.
  - A pop is first-word-fall-through: the head entry is visible on SampleData while SampleValid=1.
- Sum width 16+CNT_W cannot overflow.
- Reset mid-run forces all reset values immediately (asynchronous). Enable drops with no Done pulse.

Decomposition:
- Package rosc_pkg:
  - mode encodings MODE_STOP=2'b00, MODE_FAST=2'b01, MODE_SLOW=2'b10;
  - state enum rosc_rd_state_t {IDLE, ARM, WAIT_READY, ACK, WAIT_CLEAR, DONE};
  - struct rosc_sample_t {logic[2:0] err; logic[15:0] reading;}.
- One sub-module, rosc_sample_fifo: parameterised synchronous FWFT FIFO of rosc_sample_t. Same Clk, same async Reset, plus a flush input.

Test Plan:
- Run: Start, CfgMode=2 (slow), CfgNumClkCycles=3, NumSamples=3, with a behavioural ROSC model returning 100, 200, 300 and SampleReady=1 -> three CPUReadComplete pulses, each 1 cycle wide; SampleData sequence 100, 200, 300; Sum=600; Done pulse; Enable=0; Mode=0.
- FIFO stall: NumSamples=6, FIFO_DEPTH=4, SampleReady=0 -> exactly 4 captures, then CPUReadComplete held 0 with Busy=1 and no Timeout. Raise SampleReady -> remaining 2 captured and Done pulses.
- Timeout: model never raises ROSCValReady -> Timeout=1 after 256 cycles in WAIT_READY, Done pulse, Enable=0, FIFO empty.
- Error sample: second reading returns ErrorCode=3'b010 -> SampleErrSeen=1, SampleErr=2 on the second entry, run still completes.
- Abort in the same cycle as ROSCValReady=1 -> no push, counter unchanged, Done next cycle. Start while Busy -> ignored, configuration unchanged.
- Reset asserted mid-WAIT_CLEAR -> all outputs at reset values immediately. Post-reset Start with NumSamples=0 -> Done within 2 cycles, Enable never asserted.
